// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one core load/store request into one AXI read or write.
// Optional watchdog abort is enabled by defining AXI_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module axi4_lite_master #(
    parameter int ADDRESS        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDRESS-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,

    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,

    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,

    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,

    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi4_lite_master: DATA_WIDTH must be 32 (WSTRB is fixed at 4 bits)");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4_lite_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state_q, state_d;
    logic [ADDRESS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  timeout;

    // Only bit 1 of a response (SLVERR/DECERR) matters; EXOKAY vs OKAY is irrelevant here.
    logic unused_resp_lsb;
    assign unused_resp_lsb = M_BRESP[0] ^ M_RRESP[0];

`ifdef AXI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // All AXI VALID/READY outputs decode from registered state only, never from the peer's READY.
    assign req_ready = (state_q == IDLE);
    assign M_AWVALID = (state_q == WR_REQ) && !aw_done_q;
    assign M_WVALID  = (state_q == WR_REQ) && !w_done_q;
    assign M_BREADY  = (state_q == WR_RESP);
    assign M_ARVALID = (state_q == RD_ADDR);
    assign M_RREADY  = (state_q == RD_DATA);

    assign M_AWADDR  = addr_q;
    assign M_ARADDR  = addr_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? WR_REQ : RD_ADDR;
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together; leave once both are done.
                if (M_AWVALID && M_AWREADY) begin
                    aw_done_d = 1'b1;
                end
                if (M_WVALID && M_WREADY) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_BVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_BRESP[1];
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            RD_ADDR: begin
                if (M_ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_RVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_RRESP[1];
                    rsp_rdata_d = M_RDATA;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A real completion in the final watchdog cycle wins over the abort.
        if (timeout && !rsp_valid_d) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
